// File: rtl/elbeth_stall_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elbeth_stall_pkg
// Description : Shared definitions for the ELBETH memory-wait stall unit:
//               per-port FSM state encodings, default parameter values used
//               by the control unit and benches, and a port-index width
//               helper.
// Ports       : (package, none)
// Revision    : 1.0 - initial release
// ============================================================================
package elbeth_stall_pkg;

  // Per-port handshake FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } port_state_e;

  // Default parameter values.
  localparam int C_DEF_NUM_PORTS = 2;
  localparam int C_DEF_TIMEOUT_W = 8;
  localparam int C_DEF_CNT_W     = 16;

  // Width needed to encode a port index; never less than one bit.
  function automatic int port_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/elbeth_port_waiter.sv
`default_nettype none
// ============================================================================
// Module      : elbeth_port_waiter
// Description : One memory port's wait tracker. Follows the enable/ready
//               handshake, counts consecutive wait cycles and moves to a
//               one-cycle ABORT state once the programmable limit is reached.
// Ports       : clk        - clock
//               rst        - synchronous active-high reset
//               i_en       - request active this cycle
//               i_ready    - access completes this cycle
//               i_timeout  - wait-cycle limit, 0 disables the timeout
//               o_waiting  - request pending and not completing (combinational)
//               o_in_abort - port is in its abort cycle (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module elbeth_port_waiter
  import elbeth_stall_pkg::*;
#(
  parameter int TIMEOUT_W = C_DEF_TIMEOUT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_ready,
  input  logic [TIMEOUT_W-1:0] i_timeout,
  output logic                 o_waiting,
  output logic                 o_in_abort
);

  port_state_e          r_state;
  logic [TIMEOUT_W-1:0] r_wcnt;
  logic                 r_in_abort;

  logic                 w_req;
  logic [TIMEOUT_W-1:0] w_wcnt_inc;
  logic                 w_limit;

  assign w_req      = i_en & ~i_ready;
  assign w_wcnt_inc = r_wcnt + 1'b1;

  // r_wcnt holds the number of wait cycles already completed (0 in IDLE),
  // so w_wcnt_inc counts the current cycle too. Comparing it to the limit
  // makes the stall last exactly `timeout` cycles, with the abort cycle
  // immediately after. A ready in the compare cycle clears w_req and wins.
  assign w_limit = (i_timeout != '0) && (w_wcnt_inc == i_timeout);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wcnt     <= '0;
      r_in_abort <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_limit) begin
              r_state    <= ST_ABORT;
              r_wcnt     <= '0;
              r_in_abort <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
              r_wcnt  <= w_wcnt_inc;
            end
          end
        end
        ST_WAIT: begin
          if (!w_req) begin
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
          end else if (w_limit) begin
            r_state    <= ST_ABORT;
            r_wcnt     <= '0;
            r_in_abort <= 1'b1;
          end else begin
            r_wcnt <= w_wcnt_inc;
          end
        end
        ST_ABORT: begin
          // Inputs are ignored during the abort cycle.
          r_state    <= ST_IDLE;
          r_wcnt     <= '0;
          r_in_abort <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wcnt     <= '0;
          r_in_abort <= 1'b0;
        end
      endcase
    end
  end

  assign o_waiting  = w_req & ~r_in_abort;
  assign o_in_abort = r_in_abort;

endmodule
`default_nettype wire

// File: rtl/elbeth_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : elbeth_stall_unit
// Description : Parametrised memory-wait stall controller. Converts the
//               per-port wait status into per-stage stall/bubble controls,
//               flushes the pipe on a bus timeout and keeps a saturating
//               stall-cycle counter.
// Ports       : clk          - clock
//               rst          - synchronous active-high reset
//               mem_en       - per-port request active
//               mem_ready    - per-port access completes
//               timeout      - wait-cycle limit, 0 disables
//               cnt_clr      - clear stall-cycle counter
//               stall        - per-stage hold
//               bubble       - per-stage NOP injection
//               mem_abort    - per-port one-cycle request abort
//               exc_timeout  - one-cycle bus-timeout exception
//               exc_port     - lowest aborting port index
//               stall_cycles - saturating count of cycles with stall[0]
// Revision    : 1.0 - initial release
// ============================================================================
module elbeth_stall_unit
  import elbeth_stall_pkg::*;
#(
  parameter int NUM_PORTS = C_DEF_NUM_PORTS,
  parameter int TIMEOUT_W = C_DEF_TIMEOUT_W,
  parameter int CNT_W     = C_DEF_CNT_W,
  parameter int PW        = port_idx_w(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] mem_en,
  input  logic [NUM_PORTS-1:0] mem_ready,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic                 cnt_clr,
  output logic [NUM_PORTS-1:0] stall,
  output logic [NUM_PORTS-1:0] bubble,
  output logic [NUM_PORTS-1:0] mem_abort,
  output logic                 exc_timeout,
  output logic [PW-1:0]        exc_port,
  output logic [CNT_W-1:0]     stall_cycles
);

  logic [NUM_PORTS-1:0] w_waiting;
  logic [NUM_PORTS-1:0] w_in_abort;
  logic [NUM_PORTS-1:0] w_stall_raw;
  logic [NUM_PORTS-1:0] w_bubble_raw;
  logic [PW-1:0]        w_exc_port;
  logic                 w_exc;
  logic [CNT_W-1:0]     r_stall_cycles;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    elbeth_port_waiter #(
      .TIMEOUT_W (TIMEOUT_W)
    ) u_waiter (
      .clk        (clk),
      .rst        (rst),
      .i_en       (mem_en[gi]),
      .i_ready    (mem_ready[gi]),
      .i_timeout  (timeout),
      .o_waiting  (w_waiting[gi]),
      .o_in_abort (w_in_abort[gi])
    );
  end

  // A wait in stage j freezes every stage upstream of it: suffix OR.
  always_comb begin
    logic v_acc;
    v_acc       = 1'b0;
    w_stall_raw = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      v_acc          = v_acc | w_waiting[k];
      w_stall_raw[k] = v_acc;
    end
  end

  // Bubble the first stage that is free to move behind a held stage.
  always_comb begin
    w_bubble_raw = '0;
    for (int k = 1; k < NUM_PORTS; k++) begin
      w_bubble_raw[k] = w_stall_raw[k-1] & ~w_stall_raw[k];
    end
  end

  // Priority encoder: scanning high to low lets the lowest index win.
  always_comb begin
    w_exc_port = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (w_in_abort[k]) begin
        w_exc_port = PW'(k);
      end
    end
  end

  assign w_exc = (|w_in_abort) & ~rst;

  // An exception flushes the whole pipe: no stalls, bubbles everywhere.
  assign stall        = (rst || w_exc) ? '0 : w_stall_raw;
  assign bubble       = rst ? '0 : (w_exc ? '1 : w_bubble_raw);
  assign mem_abort    = rst ? '0 : w_in_abort;
  assign exc_timeout  = w_exc;
  assign exc_port     = w_exc ? w_exc_port : '0;
  assign stall_cycles = rst ? '0 : r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (cnt_clr) begin
      r_stall_cycles <= '0;
    end else if (stall[0] && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_elbeth_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_elbeth_stall_unit
// Description : Self-checking bench for elbeth_stall_unit (2 ports, 8-bit
//               timeout, 4-bit counter). Directed scenarios followed by
//               random traffic, all compared against a cycle-count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elbeth_stall_unit;

  localparam int NP = 2;
  localparam int TW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] mem_en, mem_ready;
  logic [TW-1:0] timeout;
  logic          cnt_clr;
  logic [NP-1:0] stall, bubble, mem_abort;
  logic          exc_timeout;
  logic          exc_port;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // Model: per port, number of consecutive wait cycles already served and
  // whether the port is in its abort cycle; plus the stall-cycle count.
  int m_cnt [NP];
  bit m_abort [NP];
  int m_sc;

  always #5 clk = ~clk;

  elbeth_stall_unit #(
    .NUM_PORTS (NP),
    .TIMEOUT_W (TW),
    .CNT_W     (CW),
    .PW        (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_en       (mem_en),
    .mem_ready    (mem_ready),
    .timeout      (timeout),
    .cnt_clr      (cnt_clr),
    .stall        (stall),
    .bubble       (bubble),
    .mem_abort    (mem_abort),
    .exc_timeout  (exc_timeout),
    .exc_port     (exc_port),
    .stall_cycles (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_idle();
    for (int i = 0; i < NP; i++) if (m_cnt[i] != 0 || m_abort[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Drive inputs (called just after a falling edge) and let them settle.
  task automatic drive(input logic [1:0] en, input logic [1:0] rdy,
                       input logic [7:0] to, input logic clr, input logic rs);
    mem_en = en; mem_ready = rdy; timeout = to; cnt_clr = clr; rst = rs;
    #1;
  endtask

  // Compare all outputs with the model, then clock and advance the model.
  task automatic step_check();
    bit w [NP];
    bit exc;
    logic [1:0] e_st, e_bb, e_ab;
    int e_port;
    for (int i = 0; i < NP; i++)
      w[i] = mem_en[i] && !mem_ready[i] && !m_abort[i];
    exc    = !rst && (m_abort[0] || m_abort[1]);
    e_port = m_abort[0] ? 0 : 1;
    if (rst) begin
      e_st = 2'b00; e_bb = 2'b00; e_ab = 2'b00;
    end else if (exc) begin
      e_st = 2'b00; e_bb = 2'b11; e_ab = {m_abort[1], m_abort[0]};
    end else begin
      e_st[1] = w[1];
      e_st[0] = w[0] || w[1];
      e_bb    = {e_st[0] && !e_st[1], 1'b0};
      e_ab    = 2'b00;
    end
    chk("stall", 32'(stall), 32'(e_st));
    chk("bubble", 32'(bubble), 32'(e_bb));
    chk("mem_abort", 32'(mem_abort), 32'(e_ab));
    chk("exc_timeout", 32'(exc_timeout), 32'(exc));
    if (exc) chk("exc_port", 32'(exc_port), 32'(e_port));
    chk("stall_cycles", 32'(stall_cycles), rst ? 32'd0 : 32'(m_sc));

    @(posedge clk);
    if (rst) begin
      m_sc = 0;
      for (int i = 0; i < NP; i++) begin m_cnt[i] = 0; m_abort[i] = 0; end
    end else begin
      if (cnt_clr) m_sc = 0;
      else if (e_st[0] && m_sc != 15) m_sc = m_sc + 1;
      for (int i = 0; i < NP; i++) begin
        if (m_abort[i]) begin
          m_abort[i] = 0; m_cnt[i] = 0;
        end else if (w[i]) begin
          if (timeout != 0 && ((m_cnt[i] + 1) % 256) == timeout) begin
            m_abort[i] = 1; m_cnt[i] = 0;
          end else begin
            m_cnt[i] = (m_cnt[i] + 1) % 256;
          end
        end else begin
          m_cnt[i] = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input logic [1:0] en, input logic [1:0] rdy,
                      input logic [7:0] to, input logic clr, input logic rs);
    drive(en, rdy, to, clr, rs);
    step_check();
  endtask

  initial begin
    int sc0;
    logic [7:0] to_r;
    for (int i = 0; i < NP; i++) begin m_cnt[i] = 0; m_abort[i] = 0; end
    m_sc = 0;
    mem_en = '0; mem_ready = '0; timeout = '0; cnt_clr = 1'b0; rst = 1'b1;
    @(negedge clk);

    // Reset: outputs forced low even with a request present.
    step(2'b11, 2'b00, 8'd0, 1'b0, 1'b1);
    step(2'b00, 2'b00, 8'd0, 1'b0, 1'b1);

    // Port 0 waits 3 cycles with no timeout, then completes.
    for (int c = 0; c < 3; c++) begin
      drive(2'b01, 2'b00, 8'd0, 1'b0, 1'b0);
      chk("t1_stall", 32'(stall), 32'h1);
      chk("t1_bubble", 32'(bubble), 32'h2);
      step_check();
    end
    step(2'b01, 2'b01, 8'd0, 1'b0, 1'b0);
    step(2'b00, 2'b00, 8'd0, 1'b0, 1'b0);

    // Port 1 waits 2 cycles; counter grows by 2.
    sc0 = int'(stall_cycles);
    for (int c = 0; c < 2; c++) begin
      drive(2'b10, 2'b00, 8'd0, 1'b0, 1'b0);
      chk("t2_stall", 32'(stall), 32'h3);
      chk("t2_bubble", 32'(bubble), 32'h0);
      step_check();
    end
    drive(2'b10, 2'b10, 8'd0, 1'b0, 1'b0);
    chk("t2_stall_rel", 32'(stall), 32'h0);
    chk("t2_count", 32'(stall_cycles), 32'(sc0 + 2));
    step_check();

    // timeout=4, port 1 never ready: stall cycles 0..3, abort cycle 4.
    for (int c = 0; c < 4; c++) begin
      drive(2'b10, 2'b00, 8'd4, 1'b0, 1'b0);
      chk("t3_stall", 32'(stall), 32'h3);
      step_check();
    end
    drive(2'b10, 2'b00, 8'd4, 1'b0, 1'b0);
    chk("t3_abort", 32'(mem_abort), 32'h2);
    chk("t3_exc", 32'(exc_timeout), 32'h1);
    chk("t3_port", 32'(exc_port), 32'h1);
    chk("t3_bubble", 32'(bubble), 32'h3);
    chk("t3_stall0", 32'(stall), 32'h0);
    step_check();
    step(2'b00, 2'b00, 8'd4, 1'b0, 1'b0);

    // Both ports time out together: one pulse, lowest port reported.
    for (int c = 0; c < 4; c++) step(2'b11, 2'b00, 8'd4, 1'b0, 1'b0);
    drive(2'b11, 2'b00, 8'd4, 1'b0, 1'b0);
    chk("t4_abort", 32'(mem_abort), 32'h3);
    chk("t4_port", 32'(exc_port), 32'h0);
    step_check();
    drive(2'b11, 2'b00, 8'd4, 1'b0, 1'b0);
    chk("t4_single", 32'(exc_timeout), 32'h0);
    step_check();
    step(2'b00, 2'b00, 8'd4, 1'b0, 1'b0);

    // timeout=3, ready in the third request cycle: no abort.
    step(2'b01, 2'b00, 8'd3, 1'b0, 1'b0);
    step(2'b01, 2'b00, 8'd3, 1'b0, 1'b0);
    step(2'b01, 2'b01, 8'd3, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      drive(2'b00, 2'b00, 8'd3, 1'b0, 1'b0);
      chk("t5_no_exc", 32'(exc_timeout), 32'h0);
      step_check();
    end

    // Reset in the middle of a wait drops the pending abort.
    step(2'b01, 2'b00, 8'd3, 1'b0, 1'b0);
    step(2'b01, 2'b00, 8'd3, 1'b0, 1'b0);
    step(2'b01, 2'b00, 8'd3, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      drive(2'b00, 2'b00, 8'd3, 1'b0, 1'b0);
      chk("t6_no_exc", 32'(exc_timeout), 32'h0);
      chk("t6_stall", 32'(stall), 32'h0);
      step_check();
    end

    // Counter saturation and clear-over-increment.
    step(2'b00, 2'b00, 8'd0, 1'b1, 1'b0);
    for (int c = 0; c < 20; c++) step(2'b01, 2'b00, 8'd0, 1'b0, 1'b0);
    drive(2'b01, 2'b00, 8'd0, 1'b0, 1'b0);
    chk("t7_sat", 32'(stall_cycles), 32'hF);
    step_check();
    step(2'b01, 2'b00, 8'd0, 1'b1, 1'b0);
    drive(2'b00, 2'b00, 8'd0, 1'b0, 1'b0);
    chk("t7_clr", 32'(stall_cycles), 32'h0);
    step_check();

    // Random traffic; timeout only changes while every port is idle.
    to_r = 8'd2;
    for (int c = 0; c < 1500; c++) begin
      logic [1:0] en, rdy;
      if (model_idle() && $urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 4))
          0: to_r = 8'd0;
          1: to_r = 8'd1;
          2: to_r = 8'd2;
          3: to_r = 8'd3;
          default: to_r = 8'd6;
        endcase
      end
      for (int i = 0; i < NP; i++) begin
        en[i]  = ($urandom_range(0, 3) != 0);
        rdy[i] = ($urandom_range(0, 2) == 0);
      end
      step(en, rdy, to_r, ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 80) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
